// File: rtl/m_sideadd_acc_pkg.sv
// m_sideadd_acc_pkg: shared state encoding for windowed stochastic stages
package m_sideadd_acc_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/m_window_cnt.sv
// m_window_cnt: window sample counter with clear, enable and terminal count
module m_window_cnt #(
    parameter int W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over enable; the final increment wraps back to zero
    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign tc = &cnt_q;
endmodule

// File: rtl/m_sideadd_acc.sv
// m_sideadd_acc: accumulates sideways-adder sums over a window of L counted samples
module m_sideadd_acc
    import m_sideadd_acc_pkg::*;
#(
    parameter int NB_in  = 3,
    parameter int W_log2 = 3,
    parameter int NB_acc = NB_in + W_log2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic              EN,
    input  logic [NB_in-1:0]  SUM_IN,
    output logic [NB_acc-1:0] ACC_OUT,
    output logic              VALID,
    output logic              BUSY
);
    if (NB_acc < NB_in + W_log2) begin : g_width_chk
        $error("m_sideadd_acc: NB_acc too narrow for a full window");
    end
    logic [1:0]        state_q, state_d;
    logic [NB_acc-1:0] acc_q, acc_d, acc_out_q, acc_out_d, acc_sum;
    logic              accum, take, last, tc;
    assign accum   = state_q == ST_ACCUM;
    assign take    = accum & EN;
    assign last    = take & tc;
    assign acc_sum = acc_q + NB_acc'(SUM_IN);
    m_window_cnt #(.W(W_log2)) u_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (!accum),
        .en    (take),
        .tc    (tc)
    );
    // next state, running sum (cleared outside ACCUM) and result capture on the last sample
    always_comb begin
        state_d   = accum ? (last ? ST_DONE : ST_ACCUM) : (START ? ST_ACCUM : ST_IDLE);
        acc_d     = take ? acc_sum : accum ? acc_q : '0;
        acc_out_d = last ? acc_sum : acc_out_q;
    end
    // state, accumulator and result registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
        end
    end
    assign ACC_OUT = acc_out_q;
    assign VALID   = state_q == ST_DONE;
    assign BUSY    = accum;
endmodule

// File: tb/tb_m_sideadd_acc.sv
// tb_m_sideadd_acc: directed self-checking bench for m_sideadd_acc (L = 8)
module tb_m_sideadd_acc;
    logic       CLK = 1'b0;
    logic       RSTn, START, EN;
    logic [2:0] SUM_IN;
    logic [5:0] ACC_OUT;
    logic       VALID, BUSY;
    int         n_chk = 0;
    int         n_fail = 0;
    int         busy_n;

    m_sideadd_acc #(.NB_in(3), .W_log2(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .EN(EN),
        .SUM_IN(SUM_IN), .ACC_OUT(ACC_OUT), .VALID(VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int acc, input int vld, input int bsy);
        chk({tag, "_acc"}, 32'(ACC_OUT), acc);
        chk({tag, "_valid"}, 32'(VALID), vld);
        chk({tag, "_busy"}, 32'(BUSY), bsy);
    endtask

    initial begin
        RSTn = 1'b1; START = 1'b0; EN = 1'b0; SUM_IN = '0;
        #3 RSTn = 1'b0;
        #1 chk_outs("reset", 0, 0, 0);
        tick(); tick();
        RSTn = 1'b1;
        tick();
        chk_outs("idle", 0, 0, 0);

        // constant 5 over a full window: total 40, BUSY exactly 8 cycles
        START = 1'b1; EN = 1'b1; SUM_IN = 3'd5;
        tick();
        START = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            busy_n += int'(BUSY);
            chk("w5_novalid", 32'(VALID), 0);
            tick();
        end
        chk_outs("w5_done", 40, 1, 0);
        EN = 1'b0;
        tick();
        chk_outs("w5_after", 40, 0, 0);
        tick();
        busy_n += int'(BUSY);
        chk("w5_busy_cycles", busy_n, 8);

        // EN toggling: only the 8th qualified sample ends the window, max value 56
        START = 1'b1;
        tick();
        START = 1'b0; SUM_IN = 3'd7;
        for (int i = 0; i < 16; i++) begin
            EN = (i % 2) == 0;
            tick();
            if (i == 14) chk_outs("w7_done", 56, 1, 0);
            else if (i < 14) chk_outs("w7_run", 40, 0, 1);
            else chk_outs("w7_idle", 56, 0, 0);
        end

        // reset mid-window: immediate clear, no VALID until a new START
        START = 1'b1; EN = 1'b1; SUM_IN = 3'd3;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 RSTn = 1'b0;
        #1 chk_outs("mid_rst", 0, 0, 0);
        tick();
        RSTn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_novalid", 32'(VALID), 0);
            chk("rst_nobusy", 32'(BUSY), 0);
        end

        // START inside ACCUM is ignored: window still ends at sample 8 with 16
        SUM_IN = 3'd2; EN = 1'b1; START = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            START = i == 3;
            tick();
            chk("ign_valid", 32'(VALID), 32'(i == 7));
        end
        chk("ign_acc", 32'(ACC_OUT), 16);
        START = 1'b0; EN = 1'b0;
        tick();
        chk_outs("ign_idle", 16, 0, 0);

        // back-to-back windows with START held: 8 then 16, VALIDs 9 cycles apart
        START = 1'b1; EN = 1'b1; SUM_IN = 3'd1;
        tick();
        for (int k = 1; k <= 17; k++) begin
            SUM_IN = k <= 8 ? 3'd1 : k == 9 ? 3'd7 : 3'd2;
            tick();
            chk("b2b_valid", 32'(VALID), 32'(k == 8 || k == 17));
            if (k == 8) chk("b2b_acc1", 32'(ACC_OUT), 8);
            if (k == 9) chk("b2b_busy", 32'(BUSY), 1);
            if (k == 16) chk("b2b_hold", 32'(ACC_OUT), 8);
            if (k == 17) chk("b2b_acc2", 32'(ACC_OUT), 16);
        end
        START = 1'b0; EN = 1'b0;
        tick();
        tick();
        chk_outs("final", 16, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
